// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and operation decode helpers for the RV32M multiply/divide unit
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // MUL is treated as unsigned: its low word does not depend on signedness.
  function automatic logic op_signed_a(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with a shared 64-bit shift accumulator
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;

  muldiv_op_e      op_in;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;

  assign op_in    = muldiv_op_e'(op_i);
  assign sign_a   = op_signed_a(op_in) & rs1_i[XLEN-1];
  assign sign_b   = op_signed_b(op_in) & rs2_i[XLEN-1];
  assign mag_a    = sign_a ? (~rs1_i + 1'b1) : rs1_i;
  assign mag_b    = sign_b ? (~rs2_i + 1'b1) : rs2_i;
  assign div_zero = is_div(op_in) && (rs2_i == '0);
  assign div_ovf  = is_div(op_in) && op_signed_a(op_in) &&
                    (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

  // Multiply: low half holds the multiplier, high half accumulates, shift right each step.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: high half is the remainder, low half shifts dividend out and quotient in.
  logic [XLEN:0]     div_pr;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_step;
  assign div_pr   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_pr[XLEN-1:0] - opb_q;
  assign div_ge   = div_pr >= {1'b0, opb_q};
  assign div_step = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                           : {div_pr[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quo_fixed, rem_fixed, fix_result;
  assign prod_fixed = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fixed  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem_fixed  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_result = '0;
    case (op_q)
      OP_MUL:                     fix_result = prod_fixed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fixed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            fix_result = quo_fixed;
      default:                    fix_result = rem_fixed;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i && !flush_i) begin
          op_d  = op_in;
          rd_d  = rd_i;
          cnt_d = '0;
          acc_d = {{XLEN{1'b0}}, mag_a};
          opb_d = mag_b;
          // Remainder takes the dividend's sign; products and quotients take sA^sB.
          neg_d = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
          if (div_zero) begin
            result_d = is_rem(op_in) ? rs1_i : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = is_rem(op_in) ? '0 : rs1_i;
            state_d  = DONE;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = is_div(op_q) ? div_step : mul_step;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          cnt_d   = '0;
          state_d = FIXUP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      FIXUP: begin
        result_d = fix_result;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign result_o    = result_q;
  assign rd_o        = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int total = 0;
  int bad = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = longint'(a);
    longint unsigned ub = longint'(b);
    int              ia = $signed(a);
    int              ib = $signed(b);
    logic [63:0]     p;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 0) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, {31'b0, in_ready_o}, 32'd1);
    op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; in_valid_i = 1'b1;
    @(posedge clk);
    #1 in_valid_i = 1'b0;
    lat = 0;
    while (out_valid_o !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, result_o, exp_res);
    chk({tag, " rd"}, {27'b0, rd_o}, {27'b0, rd});
    if (out_ready_i) begin
      @(posedge clk);
      #1 chk({tag, " back to idle"}, {30'b0, out_valid_o, in_ready_o}, 32'b01);
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        seen;

    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", {31'b0, out_valid_o}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready_o}, 32'd1);
    chk("reset result", result_o, 32'd0);
    chk("reset rd", {27'b0, rd_o}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op("MUL 7*-3", 3'd0, 32'h7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
    run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33);
    run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 33);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 5'd6, 32'd14, 33);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 5'd0, 32'd2, 33);
    run_op("DIV x/0", 3'd4, 32'h1234, 32'd0, 5'd7, 32'hFFFF_FFFF, 0);
    run_op("REMU x/0", 3'd7, 32'h1234, 32'd0, 5'd8, 32'h1234, 0);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 0);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, 0);

    out_ready_i = 1'b0;
    run_op("bp DIVU", 3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 33);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp result stable", result_o, 32'd14);
      chk("bp rd stable", {27'b0, rd_o}, 32'd11);
      chk("bp valid/ready", {30'b0, out_valid_o, in_ready_o}, 32'b10);
    end
    @(negedge clk) out_ready_i = 1'b1;
    @(posedge clk);
    #1 chk("bp release", {30'b0, out_valid_o, in_ready_o}, 32'b01);

    @(negedge clk);
    op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd12; in_valid_i = 1'b1;
    @(posedge clk);
    #1 in_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1; in_valid_i = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd4;
    @(posedge clk);
    #1 flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush to idle", {30'b0, out_valid_o, in_ready_o}, 32'b01);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) seen = 1'b1;
    end
    chk("flush no result", {31'b0, seen}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom);
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 255);
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b, rd, ref_model(op, a, b), ref_latency(op, a, b));
    end

    @(negedge clk);
    op_i = 3'd4; rs1_i = 32'd5000; rs2_i = 32'd7; rd_i = 5'd13; in_valid_i = 1'b1;
    @(posedge clk);
    #1 in_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst mid-busy valid/ready", {30'b0, out_valid_o, in_ready_o}, 32'b01);
    chk("rst mid-busy result", result_o, 32'd0);
    chk("rst mid-busy rd", {27'b0, rd_o}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("after reset MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14,
           ref_model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
